mips_pipe_hazard_ctrl: RTL and testbench

- Hazard, forwarding and run-control sequencer for the MIPS-Lite 5-stage pipeline (IF/ID/EX/MEM/WB).
- Watches the instruction in ID and keeps its own scoreboard of EX/MEM/WB destinations.
- Drives stall, flush, bubble and forwarding selects; detects HALT drain and asserts done.
- Keeps the cycle, stall, hazard and branch statistics that the top-level bench prints.

---
 rtl/mips_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mips_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_hazard_ctrl.sv
// rtl/mips_pipe_hazard_ctrl.sv - hazard, forwarding and run-control sequencer for the MIPS-Lite 5-stage pipe
// Tracks EX/MEM/WB destinations itself and derives stall/flush/bubble/forward controls from the ID instruction.
module mips_pipe_hazard_ctrl #(
  parameter int FORWARDING = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] hazard_count,
  output logic [CNT_W-1:0] branch_count
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic       ex_valid_q, ex_valid_d, ex_load_q, ex_load_d, ex_halt_q, ex_halt_d;
  logic [4:0] ex_dst_q, ex_dst_d, ex_src_a_q, ex_src_a_d, ex_src_b_q, ex_src_b_d;
  logic       mem_valid_q, mem_valid_d, mem_load_q, mem_load_d, mem_halt_q, mem_halt_d;
  logic [4:0] mem_dst_q, mem_dst_d;
  logic       wb_valid_q, wb_valid_d, wb_halt_q, wb_halt_d;
  logic [4:0] wb_dst_q, wb_dst_d;
  logic       stalled_q, stalled_d, done_q, done_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, stall_q, stall_d, hazard_q, hazard_d, branch_q, branch_d;

  logic [5:0] op;
  logic [4:0] id_src_a, id_src_b, id_dst;
  logic       id_load, id_halt, raw_hazard, stall, accept, not_done;
  logic       unused_instr_bits;

  assign op = id_instr[31:26];
  assign unused_instr_bits = ^id_instr[10:0];

  // Unused sources and absent destinations are encoded as R0, which never matches.
  function automatic logic hit(input logic [4:0] src, input logic v, input logic [4:0] dst);
    return v && (dst != 5'd0) && (src == dst);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    id_src_a = 5'd0;
    id_src_b = 5'd0;
    id_dst   = 5'd0;
    id_load  = 1'b0;
    id_halt  = 1'b0;
    if (id_valid) begin
      if (op <= 6'h0B) begin
        id_src_a = id_instr[25:21];
        if (!op[0]) begin
          id_src_b = id_instr[20:16];
          id_dst   = id_instr[15:11];
        end else begin
          id_dst   = id_instr[20:16];
        end
      end else begin
        case (op)
          6'h0C: begin id_src_a = id_instr[25:21]; id_dst = id_instr[20:16]; id_load = 1'b1; end
          6'h0D, 6'h0F: begin id_src_a = id_instr[25:21]; id_src_b = id_instr[20:16]; end
          6'h0E, 6'h10: id_src_a = id_instr[25:21];
          6'h11: id_halt = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    raw_hazard = 1'b0;
    if (FORWARDING != 0) begin
      raw_hazard = ex_valid_q && ex_load_q &&
                   (hit(id_src_a, 1'b1, ex_dst_q) || hit(id_src_b, 1'b1, ex_dst_q));
    end else begin
      raw_hazard = hit(id_src_a, ex_valid_q, ex_dst_q) || hit(id_src_b, ex_valid_q, ex_dst_q) ||
                   hit(id_src_a, mem_valid_q, mem_dst_q) || hit(id_src_b, mem_valid_q, mem_dst_q);
    end
  end

  assign stall    = (state_q == S_RUN) && !branch_taken && raw_hazard;
  assign accept   = (state_q == S_RUN) && !branch_taken && !stall;
  assign not_done = (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (accept && id_halt) state_d = S_DRAIN;
      S_DRAIN: if (wb_valid_q && wb_halt_q) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    if (!reset) begin
      case (state_q)
        S_RUN: begin
          pc_write     = !stall;
          if_id_write  = !stall;
          if_id_flush  = branch_taken;
          id_ex_bubble = stall || branch_taken;
        end
        S_DRAIN: if_id_write = 1'b1;
        default: ;
      endcase
    end
  end

  // MEM result wins over WB; a load in MEM has no data yet, so it cannot forward.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if ((FORWARDING != 0) && !reset && ex_valid_q) begin
      if (mem_valid_q && !mem_load_q && hit(ex_src_a_q, 1'b1, mem_dst_q)) fwd_a_sel = 2'b01;
      else if (hit(ex_src_a_q, wb_valid_q, wb_dst_q))                   fwd_a_sel = 2'b10;
      if (mem_valid_q && !mem_load_q && hit(ex_src_b_q, 1'b1, mem_dst_q)) fwd_b_sel = 2'b01;
      else if (hit(ex_src_b_q, wb_valid_q, wb_dst_q))                   fwd_b_sel = 2'b10;
    end
  end

  always_comb begin
    ex_valid_d  = accept && id_valid;
    ex_load_d   = accept && id_load;
    ex_halt_d   = accept && id_halt;
    ex_dst_d    = accept ? id_dst : 5'd0;
    ex_src_a_d  = accept ? id_src_a : 5'd0;
    ex_src_b_d  = accept ? id_src_b : 5'd0;
    mem_valid_d = ex_valid_q;
    mem_load_d  = ex_load_q;
    mem_halt_d  = ex_halt_q;
    mem_dst_d   = ex_dst_q;
    wb_valid_d  = mem_valid_q;
    wb_halt_d   = mem_halt_q;
    wb_dst_d    = mem_dst_q;
    stalled_d   = stall;
    done_d      = (state_d == S_DONE);
    cycle_d     = sat_inc(cycle_q, not_done);
    stall_d     = sat_inc(stall_q, stall);
    hazard_d    = sat_inc(hazard_q, stall && !stalled_q);
    branch_d    = sat_inc(branch_q, branch_taken && not_done);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      ex_valid_q <= 1'b0; ex_load_q <= 1'b0; ex_halt_q <= 1'b0;
      ex_dst_q <= 5'd0; ex_src_a_q <= 5'd0; ex_src_b_q <= 5'd0;
      mem_valid_q <= 1'b0; mem_load_q <= 1'b0; mem_halt_q <= 1'b0; mem_dst_q <= 5'd0;
      wb_valid_q <= 1'b0; wb_halt_q <= 1'b0; wb_dst_q <= 5'd0;
      stalled_q <= 1'b0; done_q <= 1'b0;
      cycle_q <= '0; stall_q <= '0; hazard_q <= '0; branch_q <= '0;
    end else begin
      state_q <= state_d;
      ex_valid_q <= ex_valid_d; ex_load_q <= ex_load_d; ex_halt_q <= ex_halt_d;
      ex_dst_q <= ex_dst_d; ex_src_a_q <= ex_src_a_d; ex_src_b_q <= ex_src_b_d;
      mem_valid_q <= mem_valid_d; mem_load_q <= mem_load_d; mem_halt_q <= mem_halt_d; mem_dst_q <= mem_dst_d;
      wb_valid_q <= wb_valid_d; wb_halt_q <= wb_halt_d; wb_dst_q <= wb_dst_d;
      stalled_q <= stalled_d; done_q <= done_d;
      cycle_q <= cycle_d; stall_q <= stall_d; hazard_q <= hazard_d; branch_q <= branch_d;
    end
  end

  assign done         = done_q;
  assign cycle_count  = cycle_q;
  assign stall_count  = stall_q;
  assign hazard_count = hazard_q;
  assign branch_count = branch_q;

endmodule

// File: tb/tb_mips_pipe_hazard_ctrl.sv
// tb/tb_mips_pipe_hazard_ctrl.sv - directed vector bench for mips_pipe_hazard_ctrl
// Two instances (no forwarding / forwarding) share the stimulus; each vector names the instance it checks.
module tb_mips_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic        branch_taken = 1'b0;

  logic [1:0]  pcw, ifw, fl, bub, dn;
  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic [31:0] cyc [2];
  logic [31:0] stl [2];
  logic [31:0] haz [2];
  logic [31:0] brc [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mips_pipe_hazard_ctrl #(.FORWARDING(0), .CNT_W(32)) dut0 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .branch_taken(branch_taken), .pc_write(pcw[0]), .if_id_write(ifw[0]),
    .if_id_flush(fl[0]), .id_ex_bubble(bub[0]), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
    .done(dn[0]), .cycle_count(cyc[0]), .stall_count(stl[0]), .hazard_count(haz[0]),
    .branch_count(brc[0]));

  mips_pipe_hazard_ctrl #(.FORWARDING(1), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .branch_taken(branch_taken), .pc_write(pcw[1]), .if_id_write(ifw[1]),
    .if_id_flush(fl[1]), .id_ex_bubble(bub[1]), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
    .done(dn[1]), .cycle_count(cyc[1]), .stall_count(stl[1]), .hazard_count(haz[1]),
    .branch_count(brc[1]));

  localparam logic [31:0] I_NOP  = 32'd0;
  localparam logic [31:0] I_ADD3 = {6'h00, 5'd1, 5'd2, 5'd3, 11'd0};
  localparam logic [31:0] I_SUB4 = {6'h02, 5'd3, 5'd1, 5'd4, 11'd0};
  localparam logic [31:0] I_OR7  = {6'h06, 5'd1, 5'd2, 5'd7, 11'd0};
  localparam logic [31:0] I_LDW5 = {6'h0C, 5'd1, 5'd5, 16'd0};
  localparam logic [31:0] I_ADD6 = {6'h00, 5'd5, 5'd2, 5'd6, 11'd0};
  localparam logic [31:0] I_ADD0 = {6'h00, 5'd1, 5'd2, 5'd0, 11'd0};
  localparam logic [31:0] I_SUBZ = {6'h02, 5'd0, 5'd1, 5'd4, 11'd0};
  localparam logic [31:0] I_BEQ  = {6'h0F, 5'd1, 5'd2, 16'd0};
  localparam logic [31:0] I_HALT = {6'h11, 26'd0};

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  localparam logic [3:0] C_OK  = 4'b1100;
  localparam logic [3:0] C_STL = 4'b0001;
  localparam logic [3:0] C_RST = 4'b0011;
  localparam logic [3:0] C_BR  = 4'b1111;
  localparam logic [3:0] C_DRN = 4'b0111;

  typedef struct {
    logic        rst;
    int          dut;
    logic        vld;
    logic [31:0] ins;
    logic        bt;
    logic [3:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        chk;
    int          stl;
    int          haz;
    int          brc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input int dut, input logic vld, input logic [31:0] ins,
                     input logic bt, input logic [3:0] ctl, input logic [1:0] a, input logic [1:0] b,
                     input logic chk, input int s, input int h, input int br);
    vec_t v;
    v.rst = rst; v.dut = dut; v.vld = vld; v.ins = ins; v.bt = bt; v.ctl = ctl;
    v.fa = a; v.fb = b; v.chk = chk; v.stl = s; v.haz = h; v.brc = br;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic vld, input logic [31:0] ins, input logic bt);
    @(posedge clock);
    #1;
    reset = rst; id_valid = vld; id_instr = ins; branch_taken = bt;
    @(negedge clock);
  endtask

  task automatic check_ctl(input string nm, input int d, input logic [3:0] ctl);
    check({nm, "_ctl"}, {28'd0, pcw[d], ifw[d], fl[d], bub[d]}, {28'd0, ctl});
  endtask

  initial begin
    // A: no forwarding, back-to-back RAW -> two stalls
    add(1, 0, 0, I_NOP,  0, C_RST, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 0, 1, I_ADD3, 0, C_OK,  2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 0, 1, I_SUB4, 0, C_STL, 2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 0, 1, I_SUB4, 0, C_STL, 2'b00, 2'b00, 1, 1, 1, 0);
    add(0, 0, 1, I_SUB4, 0, C_OK,  2'b00, 2'b00, 1, 2, 1, 0);
    add(0, 0, 0, I_NOP,  0, C_OK,  2'b00, 2'b00, 1, 2, 1, 0);
    // B: forwarding, same program -> EX/MEM forward on operand A
    add(1, 1, 0, I_NOP,  0, C_RST, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 1, 1, I_ADD3, 0, C_OK,  2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 1, 1, I_SUB4, 0, C_OK,  2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 1, 0, I_NOP,  0, C_OK,  2'b01, 2'b00, 1, 0, 0, 0);
    add(0, 1, 0, I_NOP,  0, C_OK,  2'b00, 2'b00, 1, 0, 0, 0);
    // C: forwarding, load-use -> one stall then MEM/WB forward
    add(1, 1, 0, I_NOP,  0, C_RST, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 1, 1, I_LDW5, 0, C_OK,  2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 1, 1, I_ADD6, 0, C_STL, 2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 1, 1, I_ADD6, 0, C_OK,  2'b00, 2'b00, 1, 1, 1, 0);
    add(0, 1, 0, I_NOP,  0, C_OK,  2'b10, 2'b00, 1, 1, 1, 0);
    // D: no forwarding, one gap instruction -> one stall; R0 dependency never stalls
    add(1, 0, 0, I_NOP,  0, C_RST, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 0, 1, I_ADD3, 0, C_OK,  2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 0, 1, I_OR7,  0, C_OK,  2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 0, 1, I_SUB4, 0, C_STL, 2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 0, 1, I_SUB4, 0, C_OK,  2'b00, 2'b00, 1, 1, 1, 0);
    add(0, 0, 1, I_ADD0, 0, C_OK,  2'b00, 2'b00, 1, 1, 1, 0);
    add(0, 0, 1, I_SUBZ, 0, C_OK,  2'b00, 2'b00, 1, 1, 1, 0);
    add(0, 0, 0, I_NOP,  0, C_OK,  2'b00, 2'b00, 1, 1, 1, 0);
    // E: taken branch squashes a HALT and overrides a would-be stall
    add(1, 0, 0, I_NOP,  0, C_RST, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 0, 1, I_BEQ,  0, C_OK,  2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 0, 1, I_HALT, 1, C_BR,  2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 0, 1, I_ADD3, 0, C_OK,  2'b00, 2'b00, 1, 0, 0, 1);
    add(0, 0, 1, I_SUB4, 1, C_BR,  2'b00, 2'b00, 1, 0, 0, 1);
    add(0, 0, 0, I_NOP,  0, C_OK,  2'b00, 2'b00, 1, 0, 0, 2);
    add(0, 0, 0, I_NOP,  0, C_OK,  2'b00, 2'b00, 1, 0, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      int d;
      step(vecs[i].rst, vecs[i].vld, vecs[i].ins, vecs[i].bt);
      d = vecs[i].dut;
      check($sformatf("v%0d_ctl", i), {28'd0, pcw[d], ifw[d], fl[d], bub[d]}, {28'd0, vecs[i].ctl});
      check($sformatf("v%0d_fwd_a", i), {30'd0, fa[d]}, {30'd0, vecs[i].fa});
      check($sformatf("v%0d_fwd_b", i), {30'd0, fb[d]}, {30'd0, vecs[i].fb});
      if (vecs[i].chk) begin
        check($sformatf("v%0d_stall_count", i), stl[d], vecs[i].stl);
        check($sformatf("v%0d_hazard_count", i), haz[d], vecs[i].haz);
        check($sformatf("v%0d_branch_count", i), brc[d], vecs[i].brc);
      end
    end

    // F: HALT alone from reset release -> DRAIN, done at cycle 4, cycle_count frozen
    step(1, 0, I_NOP, 0);
    check_ctl("f_reset", 0, C_RST);
    step(0, 1, I_HALT, 0);
    check_ctl("f_c0", 0, C_OK);
    check("f_c0_cycle", cyc[0], 32'd0);
    check("f_c0_done", {31'd0, dn[0]}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      step(0, 0, I_NOP, 0);
      check_ctl($sformatf("f_c%0d", c), 0, C_DRN);
      check($sformatf("f_c%0d_cycle", c), cyc[0], c);
      check($sformatf("f_c%0d_done", c), {31'd0, dn[0]}, 32'd0);
    end
    for (int c = 4; c <= 6; c++) begin
      step(0, 0, I_NOP, 0);
      check_ctl($sformatf("f_c%0d", c), 0, C_RST);
      check($sformatf("f_c%0d_cycle", c), cyc[0], 32'd4);
      check($sformatf("f_c%0d_done", c), {31'd0, dn[0]}, 32'd1);
    end
    step(1, 0, I_NOP, 0);
    step(0, 0, I_NOP, 0);
    check_ctl("f_after_done_reset", 0, C_OK);
    check("f_after_done_reset_done", {31'd0, dn[0]}, 32'd0);
    check("f_after_done_reset_cycle", cyc[0], 32'd0);

    // G: reset while draining returns to RUN with cleared counters
    step(0, 1, I_HALT, 0);
    check("g_halt_cycle", cyc[0], 32'd1);
    step(0, 0, I_NOP, 0);
    check_ctl("g_drain", 0, C_DRN);
    step(1, 0, I_NOP, 0);
    check_ctl("g_reset", 0, C_RST);
    step(0, 0, I_NOP, 0);
    check_ctl("g_run0", 0, C_OK);
    check("g_run0_cycle", cyc[0], 32'd0);
    check("g_run0_done", {31'd0, dn[0]}, 32'd0);
    check("g_run0_stall", stl[0], 32'd0);
    step(0, 0, I_NOP, 0);
    check_ctl("g_run1", 0, C_OK);
    check("g_run1_cycle", cyc[0], 32'd1);
    step(0, 0, I_NOP, 0);
    check_ctl("g_run2", 0, C_OK);
    check("g_run2_done", {31'd0, dn[0]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
